// File: rtl/br_write_arbiter_if.sv
// br_write_arbiter_if: write-back requesters plus register-bank write port.
interface br_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wa_in_clear;
    logic              wa_in_a_valid;
    logic [ADDR_W-1:0] wa_in_a_rd;
    logic [DATA_W-1:0] wa_in_a_data;
    logic              wa_out_a_ready;
    logic              wa_in_b_valid;
    logic [ADDR_W-1:0] wa_in_b_rd;
    logic [DATA_W-1:0] wa_in_b_data;
    logic              wa_out_b_ready;
    logic              wa_out_we;
    logic [ADDR_W-1:0] wa_out_rd;
    logic [DATA_W-1:0] wa_out_data;
    logic              wa_out_busy;
    logic              wa_out_last_grant;

    modport slave (
        input  wa_in_clear, wa_in_a_valid, wa_in_a_rd, wa_in_a_data,
        input  wa_in_b_valid, wa_in_b_rd, wa_in_b_data,
        output wa_out_a_ready, wa_out_b_ready, wa_out_we, wa_out_rd,
        output wa_out_data, wa_out_busy, wa_out_last_grant
    );

    modport master (
        output wa_in_clear, wa_in_a_valid, wa_in_a_rd, wa_in_a_data,
        output wa_in_b_valid, wa_in_b_rd, wa_in_b_data,
        input  wa_out_a_ready, wa_out_b_ready, wa_out_we, wa_out_rd,
        input  wa_out_data, wa_out_busy, wa_out_last_grant
    );
endinterface

// File: rtl/br_write_arbiter.sv
// br_write_arbiter: round-robin arbiter for the register-bank write port with a zeroing sweep.
module br_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input logic               wa_in_clk,
    input logic               wa_in_rst_n,
    br_write_arbiter_if.slave wa_bus
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, rd_q, rd_d, sel_rd;
    logic [DATA_W-1:0] data_q, data_d, sel_data;
    logic              we_q, we_d, busy_q, busy_d, lg_q, lg_d;
    logic              grant_a, grant_b, a_rdy, b_rdy;

    always_comb begin
        // under contention the requester not served last wins
        grant_b  = wa_bus.wa_in_b_valid & (~wa_bus.wa_in_a_valid | ~lg_q);
        grant_a  = wa_bus.wa_in_a_valid & ~grant_b;
        a_rdy    = (state_q == RUN) & grant_a & ~wa_bus.wa_in_clear;
        b_rdy    = (state_q == RUN) & grant_b & ~wa_bus.wa_in_clear;
        sel_rd   = grant_b ? wa_bus.wa_in_b_rd : wa_bus.wa_in_a_rd;
        sel_data = grant_b ? wa_bus.wa_in_b_data : wa_bus.wa_in_a_data;
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = 1'b0;
        rd_d     = rd_q;
        data_d   = data_q;
        busy_d   = busy_q;
        lg_d     = lg_q;
        if (state_q == CLEAR) begin
            we_d   = 1'b1;
            rd_d   = idx_q;
            data_d = '0;
            idx_d  = idx_q + 1'b1;
            if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
                state_d = RUN;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        end else if (wa_bus.wa_in_clear) begin
            state_d = CLEAR;
            idx_d   = '0;
            busy_d  = 1'b1;
        end else if (a_rdy | b_rdy) begin
            rd_d   = sel_rd;
            data_d = sel_data;
            lg_d   = grant_b;
            we_d   = |sel_rd;
        end
    end

    always_ff @(posedge wa_in_clk or negedge wa_in_rst_n) begin
        if (!wa_in_rst_n) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            busy_q  <= 1'b1;
            lg_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            lg_q    <= lg_d;
        end
    end

    assign wa_bus.wa_out_a_ready    = a_rdy;
    assign wa_bus.wa_out_b_ready    = b_rdy;
    assign wa_bus.wa_out_we         = we_q;
    assign wa_bus.wa_out_rd         = rd_q;
    assign wa_bus.wa_out_data       = data_q;
    assign wa_bus.wa_out_busy       = busy_q;
    assign wa_bus.wa_out_last_grant = lg_q;
endmodule

// File: tb/tb_br_write_arbiter.sv
// tb_br_write_arbiter: directed vectors, corner sequences and random traffic against a reference model.
module tb_br_write_arbiter;
    localparam int NUM = 32;

    logic clk;
    logic rst_n;
    logic mon;
    int   n_cmp;
    int   n_bad;

    br_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    br_write_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(NUM)) dut (
        .wa_in_clk  (clk),
        .wa_in_rst_n(rst_n),
        .wa_bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bdat,
                         input logic clr);
        bus.wa_in_a_valid = av;
        bus.wa_in_a_rd    = ard;
        bus.wa_in_a_data  = adat;
        bus.wa_in_b_valid = bv;
        bus.wa_in_b_rd    = brd;
        bus.wa_in_b_data  = bdat;
        bus.wa_in_clear   = clr;
    endtask

    // Reference model: count of sweep writes still owed, plus the expected bank-port registers.
    int          m_left;
    logic        m_we, m_lg;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    function automatic logic pick_b(input logic a, input logic b, input logic last);
        return (a && b) ? !last : b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= NUM;
            m_we   <= 1'b0;
            m_rd   <= '0;
            m_data <= '0;
            m_lg   <= 1'b1;
        end else if (m_left > 0) begin
            m_we   <= 1'b1;
            m_rd   <= 5'(NUM - m_left);
            m_data <= '0;
            m_left <= m_left - 1;
        end else if (bus.wa_in_clear) begin
            m_we   <= 1'b0;
            m_left <= NUM;
        end else if (bus.wa_in_a_valid || bus.wa_in_b_valid) begin
            m_lg   <= pick_b(bus.wa_in_a_valid, bus.wa_in_b_valid, m_lg);
            m_rd   <= pick_b(bus.wa_in_a_valid, bus.wa_in_b_valid, m_lg) ? bus.wa_in_b_rd : bus.wa_in_a_rd;
            m_data <= pick_b(bus.wa_in_a_valid, bus.wa_in_b_valid, m_lg) ? bus.wa_in_b_data : bus.wa_in_a_data;
            m_we   <= (pick_b(bus.wa_in_a_valid, bus.wa_in_b_valid, m_lg) ? bus.wa_in_b_rd : bus.wa_in_a_rd) != 0;
        end else begin
            m_we <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon) begin
            chk("mon_we", 32'(bus.wa_out_we), 32'(m_we));
            chk("mon_rd", 32'(bus.wa_out_rd), 32'(m_rd));
            chk("mon_data", bus.wa_out_data, m_data);
            chk("mon_busy", 32'(bus.wa_out_busy), 32'(m_left != 0));
            chk("mon_last_grant", 32'(bus.wa_out_last_grant), 32'(m_lg));
            chk("mon_a_ready", 32'(bus.wa_out_a_ready),
                32'(m_left == 0 && !bus.wa_in_clear && bus.wa_in_a_valid &&
                    !pick_b(bus.wa_in_a_valid, bus.wa_in_b_valid, m_lg)));
            chk("mon_b_ready", 32'(bus.wa_out_b_ready),
                32'(m_left == 0 && !bus.wa_in_clear && bus.wa_in_b_valid &&
                    pick_b(bus.wa_in_a_valid, bus.wa_in_b_valid, m_lg)));
        end
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bdat;
        logic        e_ra;
        logic        e_rb;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_lg;
    } vec_t;

    vec_t vt[7];
    logic a_acc, b_acc;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mon   = 1'b0;
        rst_n = 1'b0;
        a_acc = 1'b0;
        b_acc = 1'b0;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b0);
        vt[0] = '{1'b1, 5'd8, 32'hAA, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8, 32'hAA, 1'b0};
        vt[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1};
        vt[2] = '{1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2, 1'b1, 1'b0, 1'b1, 5'd9, 32'h1, 1'b0};
        vt[3] = '{1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2, 1'b0, 1'b1, 1'b1, 5'd10, 32'h2, 1'b1};
        vt[4] = '{1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2, 1'b1, 1'b0, 1'b1, 5'd9, 32'h1, 1'b0};
        vt[5] = '{1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2, 1'b0, 1'b1, 1'b1, 5'd10, 32'h2, 1'b1};
        vt[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd10, 32'h2, 1'b1};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(bus.wa_out_we), 0);
        chk("rst_rd", 32'(bus.wa_out_rd), 0);
        chk("rst_data", bus.wa_out_data, 0);
        chk("rst_busy", 32'(bus.wa_out_busy), 1);
        chk("rst_last_grant", 32'(bus.wa_out_last_grant), 1);
        chk("rst_a_ready", 32'(bus.wa_out_a_ready), 0);
        chk("rst_b_ready", 32'(bus.wa_out_b_ready), 0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        mon   = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            @(posedge clk);
            #1;
            chk("sweep_we", 32'(bus.wa_out_we), 1);
            chk("sweep_rd", 32'(bus.wa_out_rd), 32'(i));
            chk("sweep_data", bus.wa_out_data, 0);
            chk("sweep_busy", 32'(bus.wa_out_busy), 32'(i != NUM - 1));
        end
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].av, vt[i].ard, vt[i].adat, vt[i].bv, vt[i].brd, vt[i].bdat, 1'b0);
            #1;
            chk($sformatf("vec%0d_a_ready", i), 32'(bus.wa_out_a_ready), 32'(vt[i].e_ra));
            chk($sformatf("vec%0d_b_ready", i), 32'(bus.wa_out_b_ready), 32'(vt[i].e_rb));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_we", i), 32'(bus.wa_out_we), 32'(vt[i].e_we));
            chk($sformatf("vec%0d_rd", i), 32'(bus.wa_out_rd), 32'(vt[i].e_rd));
            chk($sformatf("vec%0d_data", i), bus.wa_out_data, vt[i].e_data);
            chk($sformatf("vec%0d_last_grant", i), 32'(bus.wa_out_last_grant), 32'(vt[i].e_lg));
        end
        // clear collides with a pending A write; A must wait out the whole sweep
        drive(1'b1, 5'd12, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1);
        #1;
        chk("clr_a_ready", 32'(bus.wa_out_a_ready), 0);
        @(posedge clk);
        #1;
        bus.wa_in_clear = 1'b0;
        chk("clr_busy", 32'(bus.wa_out_busy), 1);
        chk("clr_we", 32'(bus.wa_out_we), 0);
        for (int i = 0; i < NUM; i++) begin
            @(posedge clk);
            #1;
            chk("clr_sweep_rd", 32'(bus.wa_out_rd), 32'(i));
            chk("clr_sweep_we", 32'(bus.wa_out_we), 1);
            chk("clr_sweep_a_ready", 32'(bus.wa_out_a_ready), 32'(i == NUM - 1));
        end
        @(posedge clk);
        #1;
        chk("clr_after_we", 32'(bus.wa_out_we), 1);
        chk("clr_after_rd", 32'(bus.wa_out_rd), 12);
        chk("clr_after_data", bus.wa_out_data, 32'h55);
        chk("clr_after_last_grant", 32'(bus.wa_out_last_grant), 0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        bus.wa_in_clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_rd_before", 32'(bus.wa_out_rd), 15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(bus.wa_out_we), 0);
        chk("mid_rst_rd", 32'(bus.wa_out_rd), 0);
        chk("mid_rst_busy", 32'(bus.wa_out_busy), 1);
        chk("mid_rst_last_grant", 32'(bus.wa_out_last_grant), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            @(posedge clk);
            #1;
            chk("resweep_rd", 32'(bus.wa_out_rd), 32'(i));
            chk("resweep_we", 32'(bus.wa_out_we), 1);
        end
        // random traffic: requesters hold their request until accepted
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            if (!bus.wa_in_a_valid || a_acc) begin
                bus.wa_in_a_valid = 1'($urandom_range(0, 1));
                bus.wa_in_a_rd    = 5'($urandom);
                bus.wa_in_a_data  = $urandom;
            end
            if (!bus.wa_in_b_valid || b_acc) begin
                bus.wa_in_b_valid = 1'($urandom_range(0, 1));
                bus.wa_in_b_rd    = 5'($urandom);
                bus.wa_in_b_data  = $urandom;
            end
            bus.wa_in_clear = ($urandom_range(0, 59) == 0);
            #1;
            a_acc = bus.wa_out_a_ready && bus.wa_in_a_valid;
            b_acc = bus.wa_out_b_ready && bus.wa_in_b_valid;
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        mon = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/br_write_arbiter.md
# br_write_arbiter

Write-port arbiter and clear sequencer for the 32×32-bit MIPS register bank. It shares the bank's single write port between two write-back sources: requester A, the ALU/execute result, and requester B, the memory-load result. Arbitration is round-robin with a valid/ready handshake. After reset, or on command, it sweeps all 32 registers to zero, one per cycle, before any requester is served. It sits between the execute/memory stages and the register bank's rd/data/write-enable inputs.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- NUM_REGS, 32, registers swept by the clear sequence
- wa_in_clk  in  1  clock; all state updates on rising edge
- wa_in_rst_n  in  1  reset, asynchronous, active-low
- wa_in_clear  in  1  single-cycle request to start a clear sweep
- wa_in_a_valid  in  1  requester A has a write pending
- wa_in_a_rd  in  ADDR_W  requester A destination register
- wa_in_a_data  in  DATA_W  requester A write data
- wa_out_a_ready  out  1  requester A write accepted this cycle (combinational)
- wa_in_b_valid / wa_in_b_rd / wa_in_b_data / wa_out_b_ready  same as A, for requester B
- wa_out_we  out  1  register-bank write enable (registered)
- wa_out_rd  out  ADDR_W  register-bank destination index (registered)
- wa_out_data  out  DATA_W  register-bank write data (registered)
- wa_out_busy  out  1  clear sweep in progress (registered)
- wa_out_last_grant  out  1  last requester served: 0 = A, 1 = B

## Operation
- States: CLEAR and RUN. The sweep index is a 5-bit counter.
- Async reset sets: state CLEAR, index 0, wa_out_we 0, wa_out_rd 0, wa_out_data 0, wa_out_busy 1, wa_out_last_grant 1, both readys 0.
- CLEAR, on each edge:
  - wa_out_we=1, wa_out_rd=index, wa_out_data=0; index increments.
  - At the edge that issues index NUM_REGS-1, state goes to RUN, busy goes to 0 and index wraps to 0.
  - Both readys are 0 throughout.
  - wa_in_clear is ignored; the sweep does not restart.
- RUN, combinational grant:
  - Only A valid: A is granted. Only B valid: B is granted.
  - Both valid: grant goes to the requester that is not wa_out_last_grant.
  - ready = grant AND NOT wa_in_clear. A transfer is valid AND ready.
- RUN, edge with a transfer:
  - wa_out_rd and wa_out_data load the granted rd and data.
  - wa_out_last_grant loads the granted id.
  - wa_out_we = 1 if rd != 0; if rd == 0 (write to $zero), the transfer still completes but wa_out_we = 0.
- RUN, edge without a transfer: wa_out_we = 0; rd, data and last_grant hold.
- RUN with wa_in_clear=1: the clear wins over both requesters (no ready that cycle). At the edge, state goes to CLEAR with index 0 and busy 1; the first sweep write appears at the following edge.
- Requesters hold valid, rd and data stable until ready. The arbiter does not buffer a rejected request.

## Timing
- Accept to bank write: the request is accepted at edge N, wa_out_we/rd/data are valid during cycle N+1, and the bank samples them at edge N+1.
- At most one write per cycle; throughput is one write per cycle in RUN.
- Sweep length: exactly NUM_REGS cycles with wa_out_we=1.
  - The first requester can be accepted at edge NUM_REGS+1 after reset release.
  - That is one cycle after the last sweep write is loaded at edge NUM_REGS.
- Reset asserted mid-sweep or mid-transfer: all outputs return to their reset values immediately; the in-flight write is dropped.
- Back-to-back contention: with A and B both continuously valid, grants alternate A, B, A, B, … The first grant after reset is A, since last_grant resets to 1.

## Test plan
- Reset release, no requests:
  - wa_out_we=1 for 32 consecutive cycles with wa_out_rd=0,1,…,31 and data=0.
  - busy falls after the rd=31 cycle; readys stay 0 until then.
- After the sweep, A only, valid with rd=8, data=0x0000_00AA:
  - a_ready=1 the same cycle.
  - Next cycle: we=1, rd=8, data=0xAA, last_grant=0.
- A and B both held valid (A rd=9, data=1; B rd=10, data=2) for 4 cycles:
  - accepts alternate A, B, A, B.
  - Bank writes alternate (9,1), (10,2), (9,1), (10,2); last_grant toggles every cycle.
- B valid with rd=0, data=0xFFFF_FFFF:
  - b_ready=1 and the handshake completes.
  - Next cycle: we=0, last_grant=1.
- wa_in_clear asserted in the same cycle as A valid:
  - a_ready=0 that cycle; busy=1 next cycle.
  - The sweep writes 0 to rd 0–31, then A (still valid) is accepted.
- wa_in_rst_n pulsed low at sweep index 15:
  - outputs go to reset values asynchronously.
  - After release the sweep restarts at rd=0 and again runs 32 cycles.
